// File: rtl/nios2_dbg_cmd_sysclk_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nios2_dbg_cmd_sysclk_gen_if                                          |
// | Ready/valid command stream from the debug-slave FIFO to the CPU side |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface nios2_dbg_cmd_sysclk_gen_if #(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_ir, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ir, input cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/nios2_dbg_cmd_sysclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nios2_dbg_cmd_sysclk_gen                                             |
// | System-clock side of the Nios II debug slave: strobe sync, capture,  |
// | action pulses and a queued command FIFO. DBG_CMD_PARITY_EN enables   |
// | even-parity rejection of captured sr words.                          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module nios2_dbg_cmd_sysclk_gen #(
  parameter  int SR_WIDTH    = 38,
  parameter  int IR_WIDTH    = 2,
  parameter  int ACTION_BIT  = 34,
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int NUM_CHAN    = 2**IR_WIDTH
) (
  input  wire                  clk,
  input  wire                  reset,
  input  wire                  vs_uir,
  input  wire                  vs_udr,
  input  wire  [IR_WIDTH-1:0]  ir_in,
  input  wire  [SR_WIDTH-1:0]  sr,
  output logic [SR_WIDTH-1:0]  jdo,
  output logic [NUM_CHAN-1:0]  take_action,
  output logic [NUM_CHAN-1:0]  take_no_action,
  nios2_dbg_cmd_sysclk_gen_if.master cmd,
  output logic                 overflow,
  output logic [7:0]           drop_count,
  output logic                 parity_err,
  input  wire                  err_clr
);

  localparam int              C_PTR_W = $clog2(DEPTH);
  localparam logic [C_PTR_W:0] C_FULL = (C_PTR_W+1)'(DEPTH);

  logic [SYNC_STAGES-1:0] r_uir_sync, r_udr_sync, r_prime;
  logic                   r_uir_hist, r_udr_hist, r_uir_p, r_udr_p;
  logic                   w_primed;

  logic [IR_WIDTH-1:0]    r_ir_q;
  logic [SR_WIDTH-1:0]    r_jdo;
  logic [NUM_CHAN-1:0]    r_take_action, r_take_no_action;

  logic [IR_WIDTH-1:0]    r_fifo_ir [DEPTH];
  logic [SR_WIDTH-1:0]    r_fifo_sr [DEPTH];
  logic [C_PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [C_PTR_W:0]       r_count;

  logic                   r_overflow;
  logic [7:0]             r_drop_count;

  logic w_par_bad, w_accept, w_full, w_valid, w_pop, w_push, w_drop;

  // The history flops only start tracking once the reset zeros have left the
  // synchroniser, so a strobe held high through reset never looks like an edge.
  assign w_primed = r_prime[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_uir_sync <= '0;
      r_udr_sync <= '0;
      r_prime    <= '0;
      r_uir_hist <= 1'b1;
      r_udr_hist <= 1'b1;
      r_uir_p    <= 1'b0;
      r_udr_p    <= 1'b0;
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_prime    <= {r_prime[SYNC_STAGES-2:0], 1'b1};
      if (w_primed) begin
        r_uir_hist <= r_uir_sync[SYNC_STAGES-1];
        r_udr_hist <= r_udr_sync[SYNC_STAGES-1];
      end
      r_uir_p <= r_uir_sync[SYNC_STAGES-1] & ~r_uir_hist;
      r_udr_p <= r_udr_sync[SYNC_STAGES-1] & ~r_udr_hist;
    end
  end

`ifdef DBG_CMD_PARITY_EN
  logic r_parity_err;

  assign w_par_bad  = ^sr;
  assign parity_err = r_parity_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else if (r_udr_p && w_par_bad) begin
      r_parity_err <= 1'b1;
    end else if (err_clr) begin
      r_parity_err <= 1'b0;
    end
  end
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign w_accept = r_udr_p & ~w_par_bad;
  assign w_full   = (r_count == C_FULL);
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & cmd.cmd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push   = w_accept & (~w_full | w_pop);
  assign w_drop   = w_accept & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir_q           <= '0;
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_accept) begin
        r_jdo <= sr;
        if (sr[ACTION_BIT]) r_take_action[r_ir_q]    <= 1'b1;
        else                r_take_no_action[r_ir_q] <= 1'b1;
      end
      if (r_uir_p) r_ir_q <= ir_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_ir[i] <= '0;
        r_fifo_sr[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_ir[r_wr_ptr] <= r_ir_q;
        r_fifo_sr[r_wr_ptr] <= sr;
        r_wr_ptr            <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // A drop coinciding with err_clr restarts the count at one rather than zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (err_clr)                    r_drop_count <= 8'd1;
      else if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end else if (err_clr) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign jdo            = r_jdo;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign overflow       = r_overflow;
  assign drop_count     = r_drop_count;
  assign cmd.cmd_valid  = w_valid;
  assign cmd.cmd_ir     = r_fifo_ir[r_rd_ptr];
  assign cmd.cmd_data   = r_fifo_sr[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_nios2_dbg_cmd_sysclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nios2_dbg_cmd_sysclk_gen                                          |
// | Directed + random stimulus against a transaction-level queue model   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_nios2_dbg_cmd_sysclk_gen;
  localparam int SR_WIDTH   = 38;
  localparam int IR_WIDTH   = 2;
  localparam int NUM_CHAN   = 4;
  localparam int DEPTH      = 4;
  localparam int ACTION_BIT = 34;
`ifdef DBG_CMD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [IR_WIDTH-1:0] ir;
    logic [SR_WIDTH-1:0] sr;
  } cmd_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                vs_uir, vs_udr, err_clr;
  logic [IR_WIDTH-1:0] ir_in;
  logic [SR_WIDTH-1:0] sr;
  logic [SR_WIDTH-1:0] jdo;
  logic [NUM_CHAN-1:0] take_action, take_no_action;
  logic                overflow, parity_err;
  logic [7:0]          drop_count;

  nios2_dbg_cmd_sysclk_gen_if #(.SR_WIDTH(SR_WIDTH), .IR_WIDTH(IR_WIDTH)) cmd_if ();

  nios2_dbg_cmd_sysclk_gen #(
    .SR_WIDTH(SR_WIDTH), .IR_WIDTH(IR_WIDTH), .ACTION_BIT(ACTION_BIT),
    .DEPTH(DEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .cmd(cmd_if), .overflow(overflow),
    .drop_count(drop_count), .parity_err(parity_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  cmd_t q[$];
  logic [IR_WIDTH-1:0] m_ir_q;
  logic [SR_WIDTH-1:0] m_jdo;
  bit   m_ovf, m_perr;
  int   m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_ir_q = '0;
    m_jdo  = '0;
    m_ovf  = 0;
    m_perr = 0;
    m_cnt  = 0;
  endtask

  task automatic check_head(input string tag);
    check({tag, "_valid"}, 64'(cmd_if.cmd_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check({tag, "_ir"},   64'(cmd_if.cmd_ir),   64'(q[0].ir));
      check({tag, "_data"}, 64'(cmd_if.cmd_data), 64'(q[0].sr));
    end
  endtask

  task automatic uir(input logic [IR_WIDTH-1:0] ir);
    ir_in  = ir;
    vs_uir = 1'b1;
    tick(); tick();
    vs_uir = 1'b0;
    repeat (5) tick();
    m_ir_q = ir;
  endtask

  // One vs_udr strobe; optional pop and err_clr in the cycle the capture lands.
  task automatic udr(input logic [SR_WIDTH-1:0] v, input bit do_pop, input bit do_clr);
    bit reject, drop;
    logic [NUM_CHAN-1:0] exp_ta, exp_tn;
    sr     = v;
    vs_udr = 1'b1;
    tick(); tick();
    vs_udr = 1'b0;
    tick();
    if (do_pop) begin
      check_head("udr_head");
      cmd_if.cmd_ready = 1'b1;
    end
    err_clr = do_clr;
    tick();
    cmd_if.cmd_ready = 1'b0;
    err_clr = 1'b0;

    if (do_pop && q.size() > 0) void'(q.pop_front());
    reject = PAR_EN && ($countones(v) % 2 == 1);
    drop   = 0;
    exp_ta = '0;
    exp_tn = '0;
    if (!reject) begin
      m_jdo = v;
      if (v[ACTION_BIT]) exp_ta = NUM_CHAN'(1) << m_ir_q;
      else               exp_tn = NUM_CHAN'(1) << m_ir_q;
      if (q.size() < DEPTH) q.push_back('{ir: m_ir_q, sr: v});
      else drop = 1;
    end
    if (drop) begin
      m_ovf = 1;
      m_cnt = do_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    end else if (do_clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
    if (reject)      m_perr = 1;
    else if (do_clr) m_perr = 0;

    check("jdo",        64'(jdo),            64'(m_jdo));
    check("take_act",   64'(take_action),    64'(exp_ta));
    check("take_noact", 64'(take_no_action), 64'(exp_tn));
    check("valid",      64'(cmd_if.cmd_valid), 64'(q.size() > 0));
    check("overflow",   64'(overflow),       64'(m_ovf));
    check("drop_count", 64'(drop_count),     64'(m_cnt));
    check("parity_err", 64'(parity_err),     64'(m_perr));
    tick();
    check("pulse_end", 64'({take_action, take_no_action}), 64'(0));
    repeat (3) tick();
  endtask

  task automatic pop_one();
    bit had;
    check_head("pop_head");
    had = q.size() > 0;
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    if (had) void'(q.pop_front());
    check("pop_valid", 64'(cmd_if.cmd_valid), 64'(q.size() > 0));
  endtask

  task automatic clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_ovf = 0; m_cnt = 0; m_perr = 0;
    check("clr_ovf",  64'(overflow),   64'(0));
    check("clr_cnt",  64'(drop_count), 64'(0));
    check("clr_perr", 64'(parity_err), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    repeat (4) tick();
  endtask

  initial begin
    logic [63:0] rv;
    reset = 1'b1; vs_uir = 0; vs_udr = 0; err_clr = 0;
    ir_in = '0; sr = '0; cmd_if.cmd_ready = 1'b0;
    model_reset();
    tick(); tick();
    check("rst_jdo",   64'(jdo), 64'(0));
    check("rst_pulse", 64'({take_action, take_no_action}), 64'(0));
    check("rst_valid", 64'(cmd_if.cmd_valid), 64'(0));
    check("rst_ir",    64'(cmd_if.cmd_ir), 64'(0));
    check("rst_data",  64'(cmd_if.cmd_data), 64'(0));
    check("rst_err",   64'({overflow, parity_err, drop_count}), 64'(0));
    reset = 1'b0;
    repeat (4) tick();

    // single update, action on channel 2
    uir(2'd2);
    udr(38'h04_0000_00AA, 0, 0);
    pop_one();
    // no-action on channel 0
    uir(2'd0);
    udr(38'h00_1234_5678, 0, 0);
    pop_one();

    // fill, overflow on the fifth, then push+pop while full
    uir(2'd3);
    for (int i = 0; i < 5; i++) udr(38'h04_0000_0000 | 38'(i + 16), 0, 0);
    udr(38'h00_0000_0F0F, 1, 0);
    udr(38'h04_0000_0033, 0, 0);
    udr(38'h00_0000_0C0C, 0, 1);
    while (q.size() > 0) pop_one();
    clr();

    // strobe held high through reset release
    vs_udr = 1'b1;
    reset  = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("hold_pulse", 64'({take_action, take_no_action}), 64'(0));
    end
    check("hold_valid", 64'(cmd_if.cmd_valid), 64'(0));
    vs_udr = 1'b0;
    repeat (4) tick();

    // odd-parity word (rejected only when parity checking is built in)
    udr(38'h1, 0, 0);
    clr();
    while (q.size() > 0) pop_one();

    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 9);
      rv = {$urandom(), $urandom()};
      if (op < 2)       uir(IR_WIDTH'($urandom_range(0, NUM_CHAN - 1)));
      else if (op < 7)  udr(rv[SR_WIDTH-1:0], bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      else if (op < 9)  pop_one();
      else              clr();
    end

    do_reset();
    check("end_valid", 64'(cmd_if.cmd_valid), 64'(0));
    check("end_err",   64'({overflow, parity_err, drop_count}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/nios2_dbg_cmd_sysclk_gen.md
# nios2_dbg_cmd_sysclk_gen

Parametrised system-clock side of the Nios II on-chip debug slave. Synchronises the JTAG update-IR/update-DR strobes into `clk`, captures the instruction register and the scan-chain shift register, and issues one-cycle action pulses. Unlike the fixed two-bit-IR decoder, it queues every captured command in a ready/valid FIFO, so back-to-back JTAG updates are not lost when the CPU-side consumer stalls.

## Interface
Parameters:
- `SR_WIDTH`, 38: shift-register and `jdo` width; legal range 8..64.
- `IR_WIDTH`, 2: instruction-register width; `NUM_CHAN = 2**IR_WIDTH` action channels.
- `ACTION_BIT`, 34: index of the `sr` bit that selects action (1) or no-action (0); must be < `SR_WIDTH`.
- `DEPTH`, 4: command FIFO depth; power of two, ≥ 2.
- `SYNC_STAGES`, 2: synchroniser flops on `vs_udr` and `vs_uir`; legal range 2..4.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `vs_uir`  in  1: update-IR strobe, JTAG domain.
- `vs_udr`  in  1: update-DR strobe, JTAG domain.
- `ir_in`  in  `IR_WIDTH`: instruction register, JTAG domain.
- `sr`  in  `SR_WIDTH`: scan shift register, JTAG domain.
- `jdo`  out  `SR_WIDTH`: last accepted `sr` capture, held until the next accepted capture.
- `take_action`  out  `NUM_CHAN`: one-hot pulse; asserted when the `ACTION_BIT` of the capture is 1.
- `take_no_action`  out  `NUM_CHAN`: one-hot pulse; asserted when the `ACTION_BIT` of the capture is 0.
- `cmd_valid`  out  1: FIFO not empty.
- `cmd_ready`  in  1: consumer accepts the head entry.
- `cmd_ir`  out  `IR_WIDTH`: head entry IR field.
- `cmd_data`  out  `SR_WIDTH`: head entry SR field.
- `overflow`  out  1: sticky; set when a command is dropped on a full FIFO.
- `drop_count`  out  8: saturating count of dropped commands.
- `parity_err`  out  1: sticky parity-error flag (see Configuration).
- `err_clr`  in  1: clears `overflow`, `drop_count` and `parity_err`.

## Operation
- `vs_uir` and `vs_udr` each pass through `SYNC_STAGES` flops, followed by a history flop. A rising edge produces a registered one-cycle pulse, `uir_p` or `udr_p`.
- History flops reset to 1, so a strobe that is held high across reset produces no pulse.
- On `uir_p`: `ir_q <= ir_in`.
- On `udr_p`, a command is formed as {`ir_q`, `sr`}. If it is accepted:
  - `jdo <= sr`.
  - Bit `ir_q` of `take_action` or `take_no_action` (selected by `sr[ACTION_BIT]`) pulses for one cycle.
  - The command is pushed to the FIFO if it is not full.
- Full FIFO: the push is dropped; `jdo` and the pulses still update; `overflow` is set; `drop_count` increments and saturates at 255.
- Pop occurs when `cmd_valid && cmd_ready`. `cmd_ir` and `cmd_data` show the head entry combinationally from the FIFO read pointer.
- Push and pop in the same cycle while full: both take effect, no drop, count unchanged.
- Push and pop in the same cycle while empty: the push occurs; no pop takes place.
- FIFO state: read/write pointers of `log2(DEPTH)` bits that wrap modulo `DEPTH`; occupancy count of `log2(DEPTH)+1` bits.
- `err_clr` in the same cycle as a new drop: set wins. `overflow` = 1, `drop_count` = 1.
- `uir_p` and `udr_p` in the same cycle: the command uses the old `ir_q`, and `ir_q` updates afterwards.
- The JTAG side holds `sr` and `ir_in` stable for at least `SYNC_STAGES + 3` `clk` cycles after its strobe rises. This is a requirement on the JTAG side, not checked by the block.

## Timing
- Reset values: `jdo` = 0, `take_action` = 0, `take_no_action` = 0, `cmd_valid` = 0, `cmd_ir` = 0, `cmd_data` = 0, `overflow` = 0, `drop_count` = 0, `parity_err` = 0. Internal state: `ir_q` = 0, FIFO empty, synchroniser flops 0, history flops 1.
- Reset asserted mid-operation: the FIFO is flushed and in-flight pulses are lost. After release, nothing is emitted until a new rising strobe edge.
- Latency, counted in `clk` edges from the first edge that samples `vs_udr` high:
  - `udr_p` is high after edge `SYNC_STAGES + 1`.
  - `jdo`, the action pulse, `cmd_valid` and the error flags update at edge `SYNC_STAGES + 2` (edge 4 with defaults).
- Strobes must be at least 1 `clk` high and 1 `clk` low after synchronisation. Narrower strobes can be missed.
- Pop-to-`cmd_valid` response: a pop of the last entry deasserts `cmd_valid` on the next edge.

## Configuration
- `DBG_CMD_PARITY_EN` defined:
  - Even parity is computed over all `SR_WIDTH` bits of `sr` at `udr_p`.
  - Odd parity means the command is rejected: no push, no `jdo` update, no pulse, and `parity_err` is set.
  - Odd parity does not affect `overflow` or `drop_count`.
- `DBG_CMD_PARITY_EN` undefined: the parity logic is absent, `parity_err` is tied to 0, and every command is accepted.

## Test plan
- Reset, then a single update: `vs_uir` with `ir_in` = 2, then `vs_udr` with `sr` = 38'h04_0000_00AA (`ACTION_BIT` 34 = 1).
  - At edge 4: `take_action` = 4'b0100 for 1 cycle, `jdo` = 38'h04_0000_00AA.
  - `cmd_valid` = 1 with `cmd_ir` = 2; pop with `cmd_ready` = 1, then `cmd_valid` = 0.
- Five `vs_udr` strobes with `cmd_ready` = 0, `DEPTH` = 4: four entries are held in order, `overflow` = 1, `drop_count` = 1, `jdo` = fifth `sr`.
- Full FIFO with `cmd_ready` = 1 at the push cycle: no drop, occupancy stays 4, head advances.
- Strobe with `sr[34]` = 0 and `ir_in` = 0: `take_no_action` = 4'b0001, `take_action` = 0.
- `vs_udr` held high through reset release: no pulse and no push. An `err_clr` pulse in the same cycle as a drop leaves `drop_count` = 1.
- With `DBG_CMD_PARITY_EN`, `sr` = 38'h1 (odd parity): `parity_err` = 1, FIFO unchanged, no pulse. `err_clr` then sets `parity_err` = 0.
